// File: rtl/uart_pkg.sv
// Shared UART framing constants and transmit-side FSM state type.
// Included by both the transmit streamer and the receive path.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;

    // Frame markers, agreed with the receive side.
    localparam logic [7:0] START_BYTE = 8'd2;
    localparam logic [7:0] END_BYTE   = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_WAIT_RD,
        ST_DATA,
        ST_TRAIL,
        ST_FIN
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serialiser, LSB first, counterpart of uart_rx.
// Ready in the stop bit's last clock so bytes can run back-to-back.
module uart_tx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q;
    logic [CW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          last_tick;

    // Last clock of the stop bit: the line is free from the next edge.
    assign last_tick = busy_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
    assign tx_ready  = !busy_q || last_tick;
    assign tx        = tx_q;

    // Baud counting and shifting; a load drives the start bit immediately.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            tx_q    <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            busy_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= {1'b1, tx_data};
            tx_q    <= 1'b0;
        end else if (last_tick) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else if (busy_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_q  <= '0;
                bit_q   <= bit_q + 4'd1;
                tx_q    <= shift_q[0];
                shift_q <= {1'b0, shift_q[8:1]};
            end else begin
                baud_q <= baud_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_streamer.sv
// Streams a memory block to the host as START, payload, END over 8N1.
// Memory fetch of the next byte overlaps the shift of the current one.
module uart_tx_streamer #(
    parameter int         CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] START_BYTE   = uart_pkg::START_BYTE,
    parameter logic [7:0] END_BYTE     = uart_pkg::END_BYTE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sent
);

    import uart_pkg::*;

    tx_state_e         state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sent_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              ser_active_q;
    logic              payload_q;
    logic              tx_ready;
    logic              accept;
    logic              byte_end;

    // Index is one bit wider than length so a full 4095-byte block compares cleanly.
    assign idx_d    = idx_q + 1'b1;
    assign accept   = tx_valid_q && tx_ready;
    assign byte_end = ser_active_q && tx_ready;

    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent     = sent_q;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_valid(tx_valid_q),
        .tx_data (tx_data_q),
        .tx_ready(tx_ready),
        .tx      (tx)
    );

    // Frame sequencing, memory read pacing and payload byte accounting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            sent_q       <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ser_active_q <= 1'b0;
            payload_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (accept) begin
                ser_active_q <= 1'b1;
                payload_q    <= (state_q == ST_DATA);
            end else if (byte_end) begin
                ser_active_q <= 1'b0;
                payload_q    <= 1'b0;
            end

            if (byte_end && payload_q) begin
                sent_q <= sent_q + 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        len_q   <= length;
                        sent_q  <= '0;
                        idx_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= START_BYTE;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= (len_q == '0) ? ST_TRAIL : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    tx_data_q <= mem_q;
                    state_q   <= ST_DATA;
                end
                ST_DATA: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        idx_q      <= idx_d;
                        if (idx_d == {1'b0, len_q}) begin
                            state_q <= ST_TRAIL;
                        end else begin
                            addr_q  <= idx_d[ADDR_W-1:0];
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= END_BYTE;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (tx_ready && !tx_valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
